// File: rtl/bp_pkg.sv
// Shared types for the branch resolve queue: entry layout, FSM states, instruction size.
// Entry PC fields are BQ_XLEN wide; the top checks its XLEN against this at elaboration.
package bp_pkg;

  localparam int BQ_XLEN     = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [BQ_XLEN-1:0] pc;
    logic               pred_taken;
    logic [BQ_XLEN-1:0] pred_target;
  } bq_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bq_state_e;

endpackage

// File: rtl/bq_storage.sv
// DEPTH-entry branch register file: one synchronous write port, one asynchronous read port.
// Contents are not reset; validity is tracked entirely by the owner's pointers and count.
module bq_storage
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  bq_entry_t     wr_data,
  input  logic [AW-1:0] rd_addr,
  output bq_entry_t     rd_data
);

  bq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order predicted-branch queue between IF and EXE; resolve -> update/mispredict in 1 cycle.
// push_ready drops when full or during the one-cycle FLUSH after a mispredict.
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [XLEN-1:0]          push_pc,
  input  logic                     push_pred_taken,
  input  logic [XLEN-1:0]          push_pred_target,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  input  logic [XLEN-1:0]          resolve_target,
  output logic                     update,
  output logic                     actual_taken,
  output logic [XLEN-1:0]          update_pc,
  output logic                     mispredict,
  output logic [XLEN-1:0]          redirect_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underflow_err
);

  localparam int              PW       = $clog2(DEPTH);
  localparam int              CW       = PW + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(INSTR_BYTES);

  if (XLEN != BQ_XLEN) begin : g_xlen_chk
    $error("branch_resolve_queue: XLEN must equal bp_pkg::BQ_XLEN");
  end

  bq_state_e       state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            underflow_q, underflow_d;
  logic            update_q, update_d;
  logic            actual_taken_q, actual_taken_d;
  logic [XLEN-1:0] update_pc_q, update_pc_d;
  logic            mispredict_q, mispredict_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  bq_entry_t head;
  bq_entry_t wr_entry;
  logic      in_run;
  logic      push_fire;
  logic      res_fire;
  logic      mis;
  logic      flush;
  logic      wr_en;

  bq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (head)
  );

  assign in_run     = (state_q == RUN);
  assign push_ready = in_run && (count_q < FULL_CNT);
  assign push_fire  = push_valid && push_ready;
  assign res_fire   = in_run && resolve_valid && (count_q != '0);

  // A correctly predicted taken branch still mispredicts if fetch went to the wrong target.
  assign mis   = (resolve_taken != head.pred_taken) ||
                 (resolve_taken && head.pred_taken && (resolve_target != head.pred_target));
  assign flush = res_fire && mis;
  assign wr_en = push_fire && !flush;

  assign wr_entry = '{pc: push_pc, pred_taken: push_pred_taken, pred_target: push_pred_target};

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    underflow_d    = underflow_q;
    update_d       = 1'b0;
    mispredict_d   = 1'b0;
    actual_taken_d = actual_taken_q;
    update_pc_d    = update_pc_q;
    redirect_pc_d  = redirect_pc_q;

    case (state_q)
      RUN:     if (flush) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase

    if (in_run && resolve_valid && (count_q == '0)) begin
      underflow_d = 1'b1;
    end

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (res_fire) begin
      rd_ptr_d       = rd_ptr_q + PTR_ONE;
      update_d       = 1'b1;
      mispredict_d   = mis;
      actual_taken_d = resolve_taken;
      update_pc_d    = head.pc;
      redirect_pc_d  = resolve_taken ? resolve_target : (head.pc + PC_STEP);
    end

    case ({wr_en, res_fire})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Flush discards everything behind the mispredicting head, including a same-cycle push.
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= RUN;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      underflow_q    <= 1'b0;
      update_q       <= 1'b0;
      actual_taken_q <= 1'b0;
      update_pc_q    <= '0;
      mispredict_q   <= 1'b0;
      redirect_pc_q  <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      underflow_q    <= underflow_d;
      update_q       <= update_d;
      actual_taken_q <= actual_taken_d;
      update_pc_q    <= update_pc_d;
      mispredict_q   <= mispredict_d;
      redirect_pc_q  <= redirect_pc_d;
    end
  end

  assign update        = update_q;
  assign actual_taken  = actual_taken_q;
  assign update_pc     = update_pc_q;
  assign mispredict    = mispredict_q;
  assign redirect_pc   = redirect_pc_q;
  assign count         = count_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed vector table, mid-operation reset,
// pointer-wrap sequence and random traffic against a queue-based reference model.
module tb_branch_resolve_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            push_valid;
  logic            push_ready;
  logic [XLEN-1:0] push_pc;
  logic            push_pred_taken;
  logic [XLEN-1:0] push_pred_target;
  logic            resolve_valid;
  logic            resolve_taken;
  logic [XLEN-1:0] resolve_target;
  logic            update;
  logic            actual_taken;
  logic [XLEN-1:0] update_pc;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic [2:0]      count;
  logic            underflow_err;

  branch_resolve_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .push_valid       (push_valid),
    .push_ready       (push_ready),
    .push_pc          (push_pc),
    .push_pred_taken  (push_pred_taken),
    .push_pred_target (push_pred_target),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .resolve_target   (resolve_target),
    .update           (update),
    .actual_taken     (actual_taken),
    .update_pc        (update_pc),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .count            (count),
    .underflow_err    (underflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                       input logic rv, input logic rt, input logic [31:0] rtgt);
    push_valid       = pv;
    push_pc          = pc;
    push_pred_taken  = pt;
    push_pred_target = ptgt;
    resolve_valid    = rv;
    resolve_taken    = rt;
    resolve_target   = rtgt;
  endtask

  typedef struct {
    logic pv; logic [31:0] pc; logic pt; logic [31:0] ptgt;
    logic rv; logic rt; logic [31:0] rtgt;
    logic e_rdy; logic e_upd; logic e_mis; logic e_act;
    logic [31:0] e_upc; logic [31:0] e_redir; int e_cnt; logic e_uf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic pv, logic [31:0] pc, logic pt, logic [31:0] ptgt,
                             logic rv, logic rt, logic [31:0] rtgt,
                             logic rdy, logic upd, logic mis, logic act,
                             logic [31:0] upc, logic [31:0] redir, int cnt, logic uf);
    vec_t r;
    r.pv = pv; r.pc = pc; r.pt = pt; r.ptgt = ptgt;
    r.rv = rv; r.rt = rt; r.rtgt = rtgt;
    r.e_rdy = rdy; r.e_upd = upd; r.e_mis = mis; r.e_act = act;
    r.e_upc = upc; r.e_redir = redir; r.e_cnt = cnt; r.e_uf = uf;
    return r;
  endfunction

  // Reference model: plain queue of pending branches plus flush/underflow flags.
  typedef struct { logic [31:0] pc; logic pt; logic [31:0] ptgt; } ent_t;
  ent_t mq[$];
  bit   m_flush = 1'b0;
  bit   m_uf    = 1'b0;

  task automatic mstep(input logic pv, input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                       input logic rv, input logic rt, input logic [31:0] rtgt, input string tag);
    bit          rdy;
    bit          e_upd;
    bit          e_mis;
    logic        e_act;
    logic [31:0] e_upc;
    logic [31:0] e_redir;
    ent_t        h;
    ent_t        n;
    rdy   = !m_flush && (mq.size() < DEPTH);
    e_upd = 1'b0;
    e_mis = 1'b0;
    e_act = 1'b0;
    e_upc = '0;
    e_redir = '0;
    if (!m_flush && rv && mq.size() == 0) m_uf = 1'b1;
    if (!m_flush && rv && mq.size() > 0) begin
      h       = mq.pop_front();
      e_upd   = 1'b1;
      e_act   = rt;
      e_upc   = h.pc;
      e_mis   = (rt != h.pt) || (rt && (h.ptgt != rtgt));
      e_redir = rt ? rtgt : h.pc + 32'd4;
    end
    if (pv && rdy && !e_mis) begin
      n.pc = pc; n.pt = pt; n.ptgt = ptgt;
      mq.push_back(n);
    end
    if (e_mis) mq.delete();
    m_flush = e_mis;

    drive(pv, pc, pt, ptgt, rv, rt, rtgt);
    #1;
    chk({tag, " push_ready"}, push_ready, rdy);
    @(posedge clk);
    #1;
    chk({tag, " update"}, update, e_upd);
    chk({tag, " mispredict"}, mispredict, e_mis);
    chk({tag, " count"}, count, mq.size());
    chk({tag, " underflow_err"}, underflow_err, m_uf);
    if (e_upd) begin
      chk({tag, " actual_taken"}, actual_taken, e_act);
      chk({tag, " update_pc"}, update_pc, e_upc);
    end
    if (e_mis) chk({tag, " redirect_pc"}, redirect_pc, e_redir);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst count", count, 0);
    chk("rst update", update, 0);
    chk("rst mispredict", mispredict, 0);
    chk("rst underflow", underflow_err, 0);
    chk("rst push_ready", push_ready, 1);
    chk("rst update_pc", update_pc, 0);
    chk("rst redirect_pc", redirect_pc, 0);
    reset_n = 1'b1;

    //          pv  pc            pt ptgt   rv rt rtgt    rdy upd mis act upc           redir  cnt uf
    tbl.push_back(v(1, 32'h100,      1, 32'h140, 0, 0, 0,       1, 0, 0, 0, 0,            0,      1, 0));
    tbl.push_back(v(0, 0,            0, 0,       1, 1, 32'h140, 1, 1, 0, 1, 32'h100,      0,      0, 0));
    tbl.push_back(v(1, 32'h200,      0, 0,       0, 0, 0,       1, 0, 0, 0, 0,            0,      1, 0));
    tbl.push_back(v(0, 0,            0, 0,       1, 1, 32'h180, 1, 1, 1, 1, 32'h200,      32'h180,0, 0));
    tbl.push_back(v(1, 32'h999,      0, 0,       1, 0, 0,       0, 0, 0, 0, 0,            0,      0, 0));
    tbl.push_back(v(1, 32'h300,      1, 32'h340, 0, 0, 0,       1, 0, 0, 0, 0,            0,      1, 0));
    tbl.push_back(v(0, 0,            0, 0,       1, 0, 0,       1, 1, 1, 0, 32'h300,      32'h304,0, 0));
    tbl.push_back(v(0, 0,            0, 0,       0, 0, 0,       0, 0, 0, 0, 0,            0,      0, 0));
    tbl.push_back(v(1, 32'h400,      0, 0,       0, 0, 0,       1, 0, 0, 0, 0,            0,      1, 0));
    tbl.push_back(v(1, 32'h410,      0, 0,       0, 0, 0,       1, 0, 0, 0, 0,            0,      2, 0));
    tbl.push_back(v(1, 32'h420,      0, 0,       0, 0, 0,       1, 0, 0, 0, 0,            0,      3, 0));
    tbl.push_back(v(1, 32'h430,      0, 0,       0, 0, 0,       1, 0, 0, 0, 0,            0,      4, 0));
    tbl.push_back(v(1, 32'h440,      0, 0,       0, 0, 0,       0, 0, 0, 0, 0,            0,      4, 0));
    tbl.push_back(v(1, 32'h450,      0, 0,       1, 0, 0,       0, 1, 0, 0, 32'h400,      0,      3, 0));
    tbl.push_back(v(1, 32'h460,      0, 0,       1, 1, 32'h500, 1, 1, 1, 1, 32'h410,      32'h500,0, 0));
    tbl.push_back(v(0, 0,            0, 0,       0, 0, 0,       0, 0, 0, 0, 0,            0,      0, 0));
    tbl.push_back(v(0, 0,            0, 0,       1, 0, 0,       1, 0, 0, 0, 0,            0,      0, 1));
    tbl.push_back(v(0, 0,            0, 0,       0, 0, 0,       1, 0, 0, 0, 0,            0,      0, 1));
    tbl.push_back(v(1, 32'h600,      1, 32'h640, 0, 0, 0,       1, 0, 0, 0, 0,            0,      1, 1));
    tbl.push_back(v(0, 0,            0, 0,       1, 1, 32'h680, 1, 1, 1, 1, 32'h600,      32'h680,0, 1));
    tbl.push_back(v(0, 0,            0, 0,       0, 0, 0,       0, 0, 0, 0, 0,            0,      0, 1));
    tbl.push_back(v(1, 32'hFFFFFFFC, 1, 32'h10,  0, 0, 0,       1, 0, 0, 0, 0,            0,      1, 1));
    tbl.push_back(v(0, 0,            0, 0,       1, 0, 0,       1, 1, 1, 0, 32'hFFFFFFFC, 0,      0, 1));
    tbl.push_back(v(0, 0,            0, 0,       0, 0, 0,       0, 0, 0, 0, 0,            0,      0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].pv, tbl[i].pc, tbl[i].pt, tbl[i].ptgt, tbl[i].rv, tbl[i].rt, tbl[i].rtgt);
      #1;
      chk($sformatf("v%0d push_ready", i), push_ready, tbl[i].e_rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d update", i), update, tbl[i].e_upd);
      chk($sformatf("v%0d mispredict", i), mispredict, tbl[i].e_mis);
      chk($sformatf("v%0d count", i), count, tbl[i].e_cnt);
      chk($sformatf("v%0d underflow_err", i), underflow_err, tbl[i].e_uf);
      if (tbl[i].e_upd) begin
        chk($sformatf("v%0d actual_taken", i), actual_taken, tbl[i].e_act);
        chk($sformatf("v%0d update_pc", i), update_pc, tbl[i].e_upc);
      end
      if (tbl[i].e_mis) chk($sformatf("v%0d redirect_pc", i), redirect_pc, tbl[i].e_redir);
    end

    // Reset in the middle of traffic with an update pulse on the outputs.
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    mq.delete(); m_flush = 1'b0; m_uf = 1'b0;
    mstep(1, 32'h700, 0, 0, 0, 0, 0, "mr push0");
    mstep(1, 32'h710, 0, 0, 0, 0, 0, "mr push1");
    mstep(0, 0, 0, 0, 1, 0, 0, "mr resolve");
    reset_n = 1'b0;
    #1;
    chk("mid-reset update", update, 0);
    chk("mid-reset count", count, 0);
    chk("mid-reset update_pc", update_pc, 0);
    reset_n = 1'b1;
    mq.delete(); m_flush = 1'b0; m_uf = 1'b0;
    mstep(0, 0, 0, 0, 1, 0, 0, "post-reset empty resolve");

    // Ten branches, each cycle pushing one and correctly resolving the previous; pointers wrap.
    for (int k = 0; k < 10; k++) begin
      if (mq.size() > 0)
        mstep(1, 32'h1000 + 32'(k * 16), k[0], 32'h2000 + 32'(k), 1, mq[0].pt, mq[0].ptgt, $sformatf("wrap%0d", k));
      else
        mstep(1, 32'h1000 + 32'(k * 16), k[0], 32'h2000 + 32'(k), 0, 0, 0, $sformatf("wrap%0d", k));
    end
    for (int d = 0; d < 2 * DEPTH && mq.size() > 0; d++) begin
      mstep(0, 0, 0, 0, 1, mq[0].pt, mq[0].ptgt, $sformatf("drain%0d", d));
    end
    chk("wrap drained", count, 0);

    for (int r = 0; r < 400; r++) begin
      logic        rpv;
      logic        rpt;
      logic        rrv;
      logic        rrt;
      logic [31:0] rpc;
      logic [31:0] rptgt;
      logic [31:0] rrtgt;
      rpv   = ($urandom_range(0, 99) < 60);
      rpt   = $urandom_range(0, 1) == 1;
      rrv   = ($urandom_range(0, 99) < 45);
      rpc   = $urandom & 32'hFFFF_FFFC;
      rptgt = ($urandom_range(0, 1) == 1) ? 32'h40 : 32'h80;
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        rrt   = mq[0].pt;
        rrtgt = mq[0].ptgt;
      end else begin
        rrt   = $urandom_range(0, 1) == 1;
        rrtgt = ($urandom_range(0, 1) == 1) ? 32'h40 : 32'h80;
      end
      mstep(rpv, rpc, rpt, rptgt, rrv, rrt, rrtgt, $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order queue of predicted branches between fetch (IF) and execute (EXE).
- IF pushes one entry per predicted conditional branch: PC, predicted direction, predicted target.
- EXE resolves branches oldest-first. The block compares the resolved outcome with the prediction and produces a registered predictor-update strobe (update, actual_taken, branch PC) for the gshare predictor.
- On a mispredict it also raises a redirect/flush to the front end.

Parameters:
- DEPTH, 4, number of in-flight branch entries; power of two, ≥2.
- XLEN, 32, PC/target width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- push_valid  in  1  IF presents a predicted branch this cycle
- push_ready  out  1  queue accepts a push this cycle
- push_pc  in  XLEN  PC of the branch instruction
- push_pred_taken  in  1  predictor direction at fetch
- push_pred_target  in  XLEN  target used by fetch when predicted taken
- resolve_valid  in  1  EXE resolves the oldest branch this cycle
- resolve_taken  in  1  actual direction
- resolve_target  in  XLEN  actual taken target
- update  out  1  one-cycle pulse to predictor
- actual_taken  out  1  resolved direction, valid with update
- update_pc  out  XLEN  PC of the resolved branch, valid with update
- mispredict  out  1  one-cycle pulse, valid with update
- redirect_pc  out  XLEN  correct next PC, valid with mispredict
- count  out  $clog2(DEPTH)+1  current occupancy
- underflow_err  out  1  sticky: resolve arrived with queue empty

Behaviour:
- Reset (async, reset_n low):
  - rd/wr pointers, count and all output registers are 0.
  - State goes to RUN.
  - push_ready=1 once out of reset.
  - Entry storage need not be reset.
- State machine has two states, RUN and FLUSH.
  - RUN: push_ready = (count < DEPTH). A mispredict resolve moves to FLUSH.
  - FLUSH: lasts exactly one cycle, then returns to RUN. push_ready=0 and resolve_valid is ignored (front end is being redirected).
- Push: accepted when push_valid && push_ready. The entry is written at wr_ptr, wr_ptr increments modulo DEPTH, count increments.
- Resolve (RUN, count>0): reads the head entry at rd_ptr, rd_ptr increments modulo DEPTH, count decrements.
  - mis = (resolve_taken != pred_taken) || (resolve_taken && pred_taken && resolve_target != pred_target).
  - Next cycle, registered outputs:
    - update=1, actual_taken=resolve_taken, update_pc=entry pc, mispredict=mis.
    - redirect_pc = resolve_taken ? resolve_target : entry pc + 4, with XLEN wrap-around.
- Latency: resolve to update/mispredict = exactly 1 cycle. update and mispredict are single-cycle pulses.
- Mispredict flush: at the same edge as the mispredicting resolve, all entries are discarded (count=0, wr_ptr=rd_ptr), then FLUSH state.
- Empty: a resolve in RUN with count==0 sets underflow_err (sticky until reset). No update, pointers unchanged. No push-to-resolve bypass: an entry pushed in cycle N is resolvable from cycle N+1.
- Full: count==DEPTH gives push_ready=0. A pop in the same cycle does not allow a push that cycle.
- Simultaneous push and non-mispredict resolve: both take effect, count unchanged.
- Simultaneous push and mispredicting resolve: flush wins. The push is dropped and count=0.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are determined by count only.
- Reset mid-operation: all pending entries are lost and any in-flight output pulses are cleared immediately.

Decomposition:
- Shared package bp_pkg holds:
  - typedef bq_entry_t {pc, pred_taken, pred_target}
  - typedef bq_state_e {RUN, FLUSH}
  - localparam INSTR_BYTES=4
- One sub-module: bq_storage, a DEPTH×entry register file with one write port and one asynchronous read port, so the main module holds only pointers, FSM and compare logic.

Test Plan:
- Reset, then push pc=0x100, pred_taken=1, target=0x140; resolve taken, target 0x140 -> next cycle update=1, actual_taken=1, update_pc=0x100, mispredict=0; count returns to 0.
- Push pc=0x200 pred_taken=0; resolve taken, target 0x180 -> mispredict=1, redirect_pc=0x180; FLUSH cycle has push_ready=0.
- Push pc=0x300 pred_taken=1, target 0x340; resolve not taken -> mispredict=1, redirect_pc=0x304.
- Push 4 entries (DEPTH=4) -> count=4, push_ready=0. A 5th push_valid is not accepted. Resolve head plus push same cycle -> push ignored, count=3.
- With 3 entries queued, mispredict the head while push_valid=1 -> count=0 next cycle, push dropped. Later resolve with empty queue -> underflow_err=1, no update.
- Push 10 branches and resolve all correctly, interleaved -> pointers wrap; update_pc sequence matches push order exactly.
